// File: rtl/prgmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prgmem_loader_if
// Description : Signal bundle between a byte-stream host, the program-memory
//               loader and the program-memory write port / core control.
//               slave  - loader side (consumes bytes, drives memory writes)
//               master - host side (produces bytes, observes status)
//               Ports carried:
//                 i_start, i_byte_valid, i_byte_data[7:0], i_byte_last (host->loader)
//                 o_byte_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data,
//                 o_core_reset, o_busy, o_done, o_error, o_error_code[1:0],
//                 o_length (loader->host/memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface prgmem_loader_if #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH       = 4
);
  logic                         i_start;
  logic                         i_byte_valid;
  logic [7:0]                   i_byte_data;
  logic                         i_byte_last;
  logic                         o_byte_ready;
  logic                         o_prgmem_we;
  logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr;
  logic [INSTR_WIDTH-1:0]       o_prgmem_data;
  logic                         o_core_reset;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_error;
  logic [1:0]                   o_error_code;
  logic [PRGMEM_ADDR_WIDTH-1:0] o_length;

  modport slave (
    input  i_start, i_byte_valid, i_byte_data, i_byte_last,
    output o_byte_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data,
           o_core_reset, o_busy, o_done, o_error, o_error_code, o_length
  );

  modport master (
    output i_start, i_byte_valid, i_byte_data, i_byte_last,
    input  o_byte_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data,
           o_core_reset, o_busy, o_done, o_error, o_error_code, o_length
  );
endinterface
`default_nettype wire

// File: rtl/prgmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prgmem_loader
// Description : Streams Brainhack source bytes in, encodes command characters
//               into instruction words, writes them sequentially into program
//               memory, appends HALT, checks bracket balance / nesting depth
//               and keeps the core in reset until a valid image is complete.
// Ports       : i_clock  - rising-edge clock
//               i_reset  - asynchronous active-high reset
//               bus      - prgmem_loader_if.slave (byte stream in, memory
//                          write port, core reset and load status out)
// Revision    : 1.0 - initial release
// ============================================================================
module prgmem_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH       = 4,
  parameter int STACK_ADDR_WIDTH  = 4
) (
  input  wire logic       i_clock,
  input  wire logic       i_reset,
  prgmem_loader_if.slave  bus
);

  localparam logic [PRGMEM_ADDR_WIDTH-1:0] c_wp_max    = {PRGMEM_ADDR_WIDTH{1'b1}};
  localparam logic [STACK_ADDR_WIDTH-1:0]  c_depth_max = {STACK_ADDR_WIDTH{1'b1}};
  localparam logic [INSTR_WIDTH-1:0]       c_halt      = {INSTR_WIDTH{1'b1}};

  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_overflow = 2'd1;
  localparam logic [1:0] c_err_close    = 2'd2;
  localparam logic [1:0] c_err_open     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TERM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [PRGMEM_ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [STACK_ADDR_WIDTH-1:0]  depth_q, depth_d;
  logic                         we_q, we_d;
  logic [PRGMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSTR_WIDTH-1:0]       data_q, data_d;
  logic [1:0]                   code_q, code_d;

  logic                         w_ready;
  logic                         w_fire;
  logic                         w_is_instr;
  logic                         w_is_open;
  logic                         w_is_close;
  logic [3:0]                   w_opcode;
  logic [STACK_ADDR_WIDTH-1:0]  w_depth_next;

  // Character decode; anything not listed is a comment.
  always_comb begin
    w_opcode   = 4'd0;
    w_is_open  = 1'b0;
    w_is_close = 1'b0;
    case (bus.i_byte_data)
      8'h3E: w_opcode = 4'd1;                      // >
      8'h3C: w_opcode = 4'd2;                      // <
      8'h2B: w_opcode = 4'd3;                      // +
      8'h2D: w_opcode = 4'd4;                      // -
      8'h2E: w_opcode = 4'd5;                      // .
      8'h2C: w_opcode = 4'd6;                      // ,
      8'h5B: begin w_opcode = 4'd7; w_is_open  = 1'b1; end  // [
      8'h5D: begin w_opcode = 4'd8; w_is_close = 1'b1; end  // ]
      default: w_opcode = 4'd0;
    endcase
    w_is_instr = (w_opcode != 4'd0);
  end

  // A start pulse wins over the byte presented in the same cycle.
  assign w_ready = (state_q == S_LOAD) && !bus.i_start;
  assign w_fire  = w_ready && bus.i_byte_valid;

  // Only meaningful when no bracket error is flagged for this byte.
  assign w_depth_next = w_is_open  ? depth_q + STACK_ADDR_WIDTH'(1) :
                        w_is_close ? depth_q - STACK_ADDR_WIDTH'(1) : depth_q;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    depth_d = depth_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;

    if (bus.i_start) begin
      state_d = S_LOAD;
      wp_d    = '0;
      depth_d = '0;
      code_d  = c_err_none;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (w_fire) begin
            if (w_is_instr) begin
              // Overflow is checked first so it takes precedence over brackets.
              if (wp_q == c_wp_max) begin
                state_d = S_ERROR;
                code_d  = c_err_overflow;
              end else if (w_is_close && (depth_q == '0)) begin
                state_d = S_ERROR;
                code_d  = c_err_close;
              end else if (w_is_open && (depth_q == c_depth_max)) begin
                state_d = S_ERROR;
                code_d  = c_err_open;
              end else if (bus.i_byte_last && (w_depth_next != '0)) begin
                state_d = S_ERROR;
                code_d  = c_err_open;
              end else begin
                we_d    = 1'b1;
                addr_d  = wp_q;
                data_d  = INSTR_WIDTH'(w_opcode);
                wp_d    = wp_q + PRGMEM_ADDR_WIDTH'(1);
                depth_d = w_depth_next;
                if (bus.i_byte_last) begin
                  state_d = S_TERM;
                end
              end
            end else if (bus.i_byte_last) begin
              // A trailing comment has nothing to write, so HALT goes out
              // directly and TERM is skipped.
              if (depth_q != '0) begin
                state_d = S_ERROR;
                code_d  = c_err_open;
              end else begin
                we_d    = 1'b1;
                addr_d  = wp_q;
                data_d  = c_halt;
                state_d = S_DONE;
              end
            end
          end
        end
        S_TERM: begin
          we_d    = 1'b1;
          addr_d  = wp_q;
          data_d  = c_halt;
          state_d = S_DONE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      depth_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      code_q  <= c_err_none;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      depth_q <= depth_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      code_q  <= code_d;
    end
  end

  assign bus.o_byte_ready  = w_ready;
  assign bus.o_prgmem_we   = we_q;
  assign bus.o_prgmem_addr = addr_q;
  assign bus.o_prgmem_data = data_q;
  assign bus.o_core_reset  = (state_q != S_DONE);
  assign bus.o_busy        = (state_q == S_LOAD) || (state_q == S_TERM);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_error       = (state_q == S_ERROR);
  assign bus.o_error_code  = code_q;
  assign bus.o_length      = wp_q;

endmodule
`default_nettype wire

// File: tb/tb_prgmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prgmem_loader
// Description : Directed self-checking bench for prgmem_loader. Three loaders
//               share one byte stream: A (AW=8, SW=4), B (AW=3, SW=4) and
//               C (AW=8, SW=2), so capacity and depth limits can be hit with
//               short programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prgmem_loader;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       last  = 1'b0;
  logic [7:0] data  = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;

  // Write logs, each entry packed as addr*16 + data.
  int log_a[$];
  int log_b[$];
  int log_c[$];

  always #5 clk = ~clk;

  prgmem_loader_if #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4)) bus_a ();
  prgmem_loader_if #(.PRGMEM_ADDR_WIDTH(3), .INSTR_WIDTH(4)) bus_b ();
  prgmem_loader_if #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4)) bus_c ();

  assign bus_a.i_start = start;  assign bus_a.i_byte_valid = valid;
  assign bus_a.i_byte_data = data; assign bus_a.i_byte_last = last;
  assign bus_b.i_start = start;  assign bus_b.i_byte_valid = valid;
  assign bus_b.i_byte_data = data; assign bus_b.i_byte_last = last;
  assign bus_c.i_start = start;  assign bus_c.i_byte_valid = valid;
  assign bus_c.i_byte_data = data; assign bus_c.i_byte_last = last;

  prgmem_loader #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4), .STACK_ADDR_WIDTH(4))
    u_a (.i_clock(clk), .i_reset(rst), .bus(bus_a.slave));
  prgmem_loader #(.PRGMEM_ADDR_WIDTH(3), .INSTR_WIDTH(4), .STACK_ADDR_WIDTH(4))
    u_b (.i_clock(clk), .i_reset(rst), .bus(bus_b.slave));
  prgmem_loader #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4), .STACK_ADDR_WIDTH(2))
    u_c (.i_clock(clk), .i_reset(rst), .bus(bus_c.slave));

  always @(posedge clk) begin
    if (bus_a.o_prgmem_we === 1'b1) log_a.push_back(int'(bus_a.o_prgmem_addr) * 16 + int'(bus_a.o_prgmem_data));
    if (bus_b.o_prgmem_we === 1'b1) log_b.push_back(int'(bus_b.o_prgmem_addr) * 16 + int'(bus_b.o_prgmem_data));
    if (bus_c.o_prgmem_we === 1'b1) log_c.push_back(int'(bus_c.o_prgmem_addr) * 16 + int'(bus_c.o_prgmem_data));
  end

  // Present one byte (after optional idle gap) and let it cross one edge.
  task automatic send(input logic [7:0] c, input logic l, input int gap);
    repeat (gap) begin
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
    end
    @(negedge clk);
    valid = 1'b1;
    data  = c;
    last  = l;
    @(posedge clk);
  endtask

  task automatic send_str(input string s, input logic l);
    for (int i = 0; i < s.len(); i++) send(s[i], l && (i == s.len() - 1), 0);
  endtask

  task automatic drop();
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    log_a.delete();
    log_b.delete();
    log_c.delete();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus_a.o_core_reset, bus_a.o_busy, bus_a.o_done, bus_a.o_error, bus_a.o_error_code, bus_a.o_byte_ready} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 1000000", {bus_a.o_core_reset, bus_a.o_busy, bus_a.o_done, bus_a.o_error, bus_a.o_error_code, bus_a.o_byte_ready});
    end
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_length} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_write: got we=%b addr=%0d data=%0d len=%0d want all 0", bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_length);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus_a.o_core_reset, bus_a.o_busy, bus_a.o_byte_ready, bus_a.o_prgmem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 1000", {bus_a.o_core_reset, bus_a.o_busy, bus_a.o_byte_ready, bus_a.o_prgmem_we});
    end
  endtask

  task automatic test_basic();
    int exp_d[8] = '{3, 7, 4, 1, 3, 2, 8, 15};
    do_start();
    n_cmp++;
    if ({bus_a.o_busy, bus_a.o_byte_ready, bus_a.o_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_entry: got busy/ready/done=%b want 110", {bus_a.o_busy, bus_a.o_byte_ready, bus_a.o_done});
    end
    send_str("+[->+<]", 1'b1);
    drop();  // cycle N+1: last instruction write
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_done} !== {1'b1, 8'd6, 4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_last_write: got we=%b addr=%0d data=%0d done=%b want 1/6/8/0", bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_done);
    end
    @(negedge clk); #1;  // cycle N+2: HALT with done
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_done, bus_a.o_core_reset, bus_a.o_busy} !== {1'b1, 8'd7, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_halt: got we=%b addr=%0d data=%0d done=%b crst=%b busy=%b want 1/7/15/1/0/0", bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_done, bus_a.o_core_reset, bus_a.o_busy);
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_length, bus_a.o_done} !== {1'b0, 8'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_hold: got we=%b len=%0d done=%b want 0/7/1", bus_a.o_prgmem_we, bus_a.o_length, bus_a.o_done);
    end
    n_cmp++;
    if (log_a.size() !== 8) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes want 8", log_a.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (log_a[i] !== i * 16 + exp_d[i]) begin
          n_fail++;
          $display("FAIL basic_write%0d: got addr=%0d data=%0d want addr=%0d data=%0d", i, log_a[i] / 16, log_a[i] % 16, i, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_comments();
    logic [7:0] chars[6] = '{8'h61, 8'h2B, 8'h20, 8'h62, 8'h0A, 8'h2D};
    int         gaps[6]  = '{2, 0, 3, 1, 0, 2};
    do_start();
    for (int i = 0; i < 6; i++) send(chars[i], i == 5, gaps[i]);
    drop();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (log_a.size() !== 3) begin
      n_fail++;
      $display("FAIL comments_count: got %0d writes want 3", log_a.size());
    end else begin
      n_cmp++;
      if ({log_a[0], log_a[1], log_a[2]} !== {32'h03, 32'h14, 32'h2F}) begin
        n_fail++;
        $display("FAIL comments_writes: got %h %h %h want 03 14 2f", log_a[0], log_a[1], log_a[2]);
      end
    end
    n_cmp++;
    if ({bus_a.o_length, bus_a.o_done, bus_a.o_error} !== {8'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL comments_status: got len=%0d done=%b err=%b want 2/1/0", bus_a.o_length, bus_a.o_done, bus_a.o_error);
    end
  endtask

  task automatic test_unmatched_close();
    do_start();
    send_str("+]", 1'b0);
    drop();
    n_cmp++;
    if ({bus_a.o_error, bus_a.o_error_code, bus_a.o_byte_ready, bus_a.o_core_reset} !== 5'b1_10_0_1) begin
      n_fail++;
      $display("FAIL close_error: got err=%b code=%0d ready=%b crst=%b want 1/2/0/1", bus_a.o_error, bus_a.o_error_code, bus_a.o_byte_ready, bus_a.o_core_reset);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (log_a.size() !== 1 || log_a[0] !== 32'h03 || bus_a.o_length !== 8'd1 || bus_a.o_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL close_writes: got %0d writes len=%0d crst=%b want 1 write (0,3) len=1 crst=1", log_a.size(), bus_a.o_length, bus_a.o_core_reset);
    end
  endtask

  task automatic test_unclosed();
    do_start();
    send_str("[[+]", 1'b1);
    drop();
    n_cmp++;
    if ({bus_a.o_error, bus_a.o_error_code} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL unclosed_error: got err=%b code=%0d want 1/3", bus_a.o_error, bus_a.o_error_code);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (log_a.size() !== 3 || bus_a.o_length !== 8'd3 || bus_a.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL unclosed_nohalt: got %0d writes len=%0d done=%b want 3/3/0", log_a.size(), bus_a.o_length, bus_a.o_done);
    end
  endtask

  task automatic test_depth();
    do_start();
    send_str("[[[", 1'b0);
    drop();
    n_cmp++;
    if (bus_c.o_error !== 1'b0) begin
      n_fail++;
      $display("FAIL depth_at_max: got err=%b want 0", bus_c.o_error);
    end
    send("[", 1'b0, 0);
    drop();
    n_cmp++;
    if ({bus_c.o_error, bus_c.o_error_code, bus_a.o_error, bus_a.o_busy} !== 5'b1_11_0_1) begin
      n_fail++;
      $display("FAIL depth_exceeded: got c_err=%b c_code=%0d a_err=%b a_busy=%b want 1/3/0/1", bus_c.o_error, bus_c.o_error_code, bus_a.o_error, bus_a.o_busy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (log_c.size() !== 3) begin
      n_fail++;
      $display("FAIL depth_writes: got %0d writes want 3", log_c.size());
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 7; i++) send("+", 1'b0, 0);
    drop();
    n_cmp++;
    if (bus_b.o_error !== 1'b0 || bus_b.o_length !== 3'd7) begin
      n_fail++;
      $display("FAIL overflow_full: got err=%b len=%0d want 0/7", bus_b.o_error, bus_b.o_length);
    end
    send("+", 1'b0, 0);
    drop();
    n_cmp++;
    if ({bus_b.o_error, bus_b.o_error_code, bus_b.o_length} !== {1'b1, 2'd1, 3'd7}) begin
      n_fail++;
      $display("FAIL overflow_error: got err=%b code=%0d len=%0d want 1/1/7", bus_b.o_error, bus_b.o_error_code, bus_b.o_length);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (log_b.size() !== 7) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes want 7", log_b.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (log_b[i] !== i * 16 + 3) begin
          n_fail++;
          $display("FAIL overflow_write%0d: got %h want %h", i, log_b[i], i * 16 + 3);
        end
      end
    end
    // Restart with a byte already valid: it must not be taken during start.
    @(negedge clk);
    start = 1'b1;
    valid = 1'b1;
    data  = "+";
    last  = 1'b1;
    #1;
    n_cmp++;
    if ({bus_a.o_byte_ready, bus_b.o_byte_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_blocks_ready: got a=%b b=%b want 0 0", bus_a.o_byte_ready, bus_b.o_byte_ready);
    end
    @(negedge clk);
    start = 1'b0;
    log_a.delete();
    log_b.delete();
    log_c.delete();
    #1;
    n_cmp++;
    if ({bus_b.o_length, bus_b.o_error, bus_b.o_busy, bus_b.o_byte_ready} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_state: got len=%0d err=%b busy=%b ready=%b want 0/0/1/1", bus_b.o_length, bus_b.o_error, bus_b.o_busy, bus_b.o_byte_ready);
    end
    @(posedge clk);
    drop();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (log_b.size() !== 2 || log_b[0] !== 32'h03 || log_b[1] !== 32'h1F) begin
      n_fail++;
      $display("FAIL restart_writes: got %0d writes want 2 (0,3)(1,15)", log_b.size());
    end
    n_cmp++;
    if ({bus_b.o_done, bus_b.o_core_reset, bus_b.o_length} !== {1'b1, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b crst=%b len=%0d want 1/0/1", bus_b.o_done, bus_b.o_core_reset, bus_b.o_length);
    end
  endtask

  task automatic test_reset_midload();
    do_start();
    send("+", 1'b0, 0);
    send("+", 1'b0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data} !== {1'b1, 8'd1, 4'd3}) begin
      n_fail++;
      $display("FAIL midload_write: got we=%b addr=%0d data=%0d want 1/1/3", bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_length, bus_a.o_core_reset, bus_a.o_busy, bus_a.o_byte_ready} !== {1'b0, 8'd0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got we=%b addr=%0d data=%0d len=%0d crst=%b busy=%b ready=%b want 0/0/0/0/1/0/0", bus_a.o_prgmem_we, bus_a.o_prgmem_addr, bus_a.o_prgmem_data, bus_a.o_length, bus_a.o_core_reset, bus_a.o_busy, bus_a.o_byte_ready);
    end
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (log_a.size() !== 1 || bus_a.o_busy !== 1'b0 || bus_a.o_byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_write: got %0d writes busy=%b ready=%b want 1/0/0", log_a.size(), bus_a.o_busy, bus_a.o_byte_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_comments();
    test_unmatched_close();
    test_unclosed();
    test_depth();
    test_overflow();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
